// File: rtl/cs_result_buffer.sv
// Result buffer behind the sliding-window averager: drops warm-up results,
// queues the rest in a show-ahead FIFO, and counts results lost on overflow.
module cs_result_buffer #(
    parameter int DW     = 10,
    parameter int DEPTH  = 8,
    parameter int WARMUP = 8,
    parameter int CW     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       restart,
    input  logic                       in_valid,
    input  logic [DW-1:0]              y_in,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [DW-1:0]              out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [CW-1:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WW-1:0] WARM_LAST = WW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);

    typedef enum logic {WARM, RUN} state_t;
    localparam state_t INIT_ST = (WARMUP == 0) ? RUN : WARM;

    state_t          state_q, state_d;
    logic [WW-1:0]   warm_q, warm_d;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d, rd_nx;
    logic [AW:0]     count_q, count_d;
    logic [DW-1:0]   data_q, data_d;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic            push, pop, drop;
    logic [DW-1:0]   mem [DEPTH];

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign rd_nx = rd_q + 1'b1;

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        push    = 1'b0;
        pop     = 1'b0;
        drop    = 1'b0;

        if (restart) begin
            state_d = INIT_ST;
            warm_d  = '0;
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            drop_d  = '0;
        end else begin
            pop = (count_q != '0) && out_ready;
            case (state_q)
                WARM: begin
                    if (in_valid) begin
                        warm_d = warm_q + 1'b1;
                        if (warm_q == WARM_LAST) state_d = RUN;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        if ((count_q != FULL) || pop) push = 1'b1;
                        else                          drop = 1'b1;
                    end
                end
                default: state_d = INIT_ST;
            endcase

            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_nx;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;

            // Keep the head register in step with mem[rd_ptr]; a push into an
            // otherwise-empty FIFO bypasses memory so first-word latency is one edge.
            if (pop) begin
                if (count_q == (AW+1)'(1)) begin
                    if (push) data_d = y_in;
                end else begin
                    data_d = mem[rd_nx];
                end
            end else if (push && (count_q == '0)) begin
                data_d = y_in;
            end

            if (drop) begin
                ovf_d  = 1'b1;
                drop_d = sat_inc(drop_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT_ST;
            warm_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= y_in;
    end

    assign out_valid = (count_q != '0);
    assign out_data  = data_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_cs_result_buffer.sv
// Directed bench for cs_result_buffer: vector table for warm-up/fill/drain,
// hand sequences for full push+pop, backpressure, restart and async reset.
module tb_cs_result_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        restart;
    logic        in_valid;
    logic [9:0]  y_in;
    logic        out_ready;
    logic        out_valid;
    logic [9:0]  out_data;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    cs_result_buffer #(.DW(10), .DEPTH(8), .WARMUP(8), .CW(8)) dut (
        .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid),
        .y_in(y_in), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .count(count), .overflow(overflow),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [9:0] y;
        logic       rdy;
        logic       ev;
        logic [9:0] ed;
        logic [3:0] ec;
        logic       eo;
        logic [7:0] edc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input int y, input logic rdy, input logic ev,
                       input int ed, input int ec, input logic eo, input int edc);
        vec_t v;
        v.iv = iv; v.y = 10'(y); v.rdy = rdy; v.ev = ev; v.ed = 10'(ed);
        v.ec = 4'(ec); v.eo = eo; v.edc = 8'(edc);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] exps [8];
        logic [9:0] exp_q [$];
        logic [9:0] pd;
        logic       stall;
        int         nxt;
        int         popped;

        reset = 1'b1; restart = 1'b0; in_valid = 1'b0; y_in = '0; out_ready = 1'b0;

        // Warm-up: 8 discarded beats, then 100 appears one edge later and drains.
        for (int k = 1; k <= 8; k++) add(1, k, 1, 0, 0, 0, 0, 0);
        add(1, 100, 1, 1, 100, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        // Fill with 200..209 under backpressure: two drops.
        for (int k = 0; k < 8; k++) add(1, 200 + k, 0, 1, 200, k + 1, 0, 0);
        add(1, 208, 0, 1, 200, 8, 1, 1);
        add(1, 209, 0, 1, 200, 8, 1, 2);
        // Drain in order.
        for (int k = 1; k <= 7; k++) add(0, 0, 1, 1, 200 + k, 8 - k, 1, 2);
        add(0, 0, 1, 0, 0, 0, 1, 2);

        #2;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", drop_cnt, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            in_valid = vecs[i].iv; y_in = vecs[i].y; out_ready = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d_valid", i), out_valid, vecs[i].ev);
            if (vecs[i].ev) check($sformatf("vec%0d_data", i), out_data, vecs[i].ed);
            check($sformatf("vec%0d_count", i), count, vecs[i].ec);
            check($sformatf("vec%0d_ovf", i), overflow, vecs[i].eo);
            check($sformatf("vec%0d_drop", i), drop_cnt, vecs[i].edc);
        end

        // Full FIFO with simultaneous push and pop: no drop.
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; y_in = 10'(50 + k); tick();
        end
        check("full_count", count, 8);
        check("full_head", out_data, 50);
        y_in = 10'd300; out_ready = 1'b1; tick();
        check("pp_count", count, 8);
        check("pp_drop", drop_cnt, 2);
        check("pp_head", out_data, 51);
        in_valid = 1'b0;
        exps = '{10'd52, 10'd53, 10'd54, 10'd55, 10'd56, 10'd57, 10'd300, 10'd0};
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("pp_drain%0d", k), out_data, exps[k]);
            check($sformatf("pp_cnt%0d", k), count, 7 - k);
        end
        tick();
        check("pp_empty", out_valid, 0);

        // Backpressure: ready toggles while streaming 10..40.
        nxt = 10; popped = 0; stall = 1'b0; pd = '0;
        for (int cyc = 0; cyc < 200 && (nxt <= 40 || exp_q.size() > 0); cyc++) begin
            out_ready = (cyc % 2 == 1);
            in_valid  = (nxt <= 40) && (exp_q.size() < 7);
            y_in      = 10'(nxt);
            check("bp_valid", out_valid, exp_q.size() != 0);
            if (stall) check("bp_stable", out_data, pd);
            if (out_valid && out_ready && exp_q.size() > 0) begin
                check("bp_order", out_data, exp_q.pop_front());
                popped++;
            end
            stall = out_valid && !out_ready;
            pd    = out_data;
            if (in_valid) begin
                exp_q.push_back(10'(nxt));
                nxt++;
            end
            tick();
            check("bp_count", count, exp_q.size());
        end
        check("bp_popped", popped, 31);
        check("bp_drop", drop_cnt, 2);

        // Restart mid-stream with count=5 and overflow set.
        in_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            y_in = 10'(60 + k); tick();
        end
        check("pre_rs_count", count, 5);
        check("pre_rs_ovf", overflow, 1);
        restart = 1'b1; y_in = 10'd999; tick();
        restart = 1'b0;
        check("rs_count", count, 0);
        check("rs_valid", out_valid, 0);
        check("rs_ovf", overflow, 0);
        check("rs_drop", drop_cnt, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            y_in = 10'(k + 1); tick();
            check($sformatf("rs_warm%0d", k), out_valid, 0);
        end
        y_in = 10'd77; tick();
        check("rs_first_valid", out_valid, 1);
        check("rs_first_data", out_data, 77);
        in_valid = 1'b0; tick();
        check("rs_drained", out_valid, 0);

        // Asynchronous reset between edges with count=3.
        in_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            y_in = 10'(5 + k); tick();
        end
        in_valid = 1'b0;
        check("ar_pre_count", count, 3);
        check("ar_pre_data", out_data, 5);
        #2 reset = 1'b1;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_data", out_data, 0);
        check("ar_count", count, 0);
        check("ar_ovf", overflow, 0);
        check("ar_drop", drop_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
